// File: rtl/tm1637_tx_if.sv
// rtl/tm1637_tx_if.sv - host request/status and bus pin signals of the TM1637 transmitter
interface tm1637_tx_if #(parameter int NUM_DIGITS = 4);
  logic                    start;
  logic [8*NUM_DIGITS-1:0] digits;
  logic [2:0]              brightness;
  logic                    display_on;
  logic                    busy;
  logic                    done;
  logic                    ack_err;
  logic                    tm_clk;
  logic                    tm_dio_oe;
  logic                    tm_dio_i;

  modport master (
    output start, digits, brightness, display_on, tm_dio_i,
    input  busy, done, ack_err, tm_clk, tm_dio_oe
  );

  modport slave (
    input  start, digits, brightness, display_on, tm_dio_i,
    output busy, done, ack_err, tm_clk, tm_dio_oe
  );
endinterface

// File: rtl/tm1637_tx.sv
// rtl/tm1637_tx.sv - TM1637 display image transmitter (data cmd, address+digits, display ctrl)
// Optional ACK checking enabled by defining TM1637_ACK_CHECK_EN.
module tm1637_tx #(
  parameter int CLK_DIV    = 250,
  parameter int NUM_DIGITS = 4
) (
  input logic        clock_i,
  input logic        reset_n_i,
  tm1637_tx_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] START_A = 4'd1;
  localparam logic [3:0] START_B = 4'd2;
  localparam logic [3:0] BIT_LO  = 4'd3;
  localparam logic [3:0] BIT_HI  = 4'd4;
  localparam logic [3:0] ACK_LO  = 4'd5;
  localparam logic [3:0] ACK_HI  = 4'd6;
  localparam logic [3:0] STOP_A  = 4'd7;
  localparam logic [3:0] STOP_B  = 4'd8;
  localparam logic [3:0] STOP_C  = 4'd9;

  logic [3:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              frame_q, frame_d;
  logic [2:0]              byte_q, byte_d;
  logic [2:0]              bit_q, bit_d;
  logic [8*NUM_DIGITS-1:0] digits_q;
  logic [2:0]              bri_q;
  logic                    on_q;
  logic                    busy_q, done_q, done_d;
  logic                    clk_q, clk_d, oe_q, oe_d;
  logic                    tick, last_byte, accept;
  logic [7:0]              tx_d;

  assign accept    = (state_q == IDLE) && bus.start;
  assign tick      = (state_q != IDLE) && (cnt_q == CW'(CLK_DIV - 1));
  assign last_byte = (frame_q == 2'd1) ? (byte_q == 3'(NUM_DIGITS)) : (byte_q == 3'd0);
  assign cnt_d     = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = START_A;
        frame_d = 2'd0;
        byte_d  = 3'd0;
        bit_d   = 3'd0;
      end
    end else if (tick) begin
      case (state_q)
        START_A: state_d = START_B;
        START_B: state_d = BIT_LO;
        BIT_LO:  state_d = BIT_HI;
        BIT_HI: begin
          if (bit_q == 3'd7) begin
            state_d = ACK_LO;
            bit_d   = 3'd0;
          end else begin
            state_d = BIT_LO;
            bit_d   = bit_q + 3'd1;
          end
        end
        ACK_LO:  state_d = ACK_HI;
        ACK_HI: begin
          if (last_byte) begin
            state_d = STOP_A;
            byte_d  = 3'd0;
          end else begin
            state_d = BIT_LO;
            byte_d  = byte_q + 3'd1;
          end
        end
        STOP_A:  state_d = STOP_B;
        STOP_B:  state_d = STOP_C;
        STOP_C: begin
          if (frame_q == 2'd2) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = START_A;
            frame_d = frame_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte about to be shifted, looked up from the next-state indices so pins are registered
  always_comb begin
    tx_d = 8'h00;
    case (frame_d)
      2'd0: tx_d = 8'h40;
      2'd1: begin
        tx_d = 8'hC0;
        for (int k = 0; k < NUM_DIGITS; k++)
          if (byte_d == 3'(k + 1)) tx_d = digits_q[8*k +: 8];
      end
      default: tx_d = {4'h8, on_q, bri_q};
    endcase
  end

  always_comb begin
    clk_d = 1'b1;
    oe_d  = 1'b0;
    case (state_d)
      START_A: oe_d = 1'b1;
      START_B: begin clk_d = 1'b0; oe_d = 1'b1; end
      BIT_LO:  begin clk_d = 1'b0; oe_d = ~tx_d[bit_d]; end
      BIT_HI:  oe_d = ~tx_d[bit_d];
      ACK_LO:  clk_d = 1'b0;
      STOP_A:  begin clk_d = 1'b0; oe_d = 1'b1; end
      STOP_B:  oe_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      frame_q  <= 2'd0;
      byte_q   <= 3'd0;
      bit_q    <= 3'd0;
      digits_q <= '0;
      bri_q    <= 3'd0;
      on_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_q    <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      clk_q   <= clk_d;
      oe_q    <= oe_d;
      if (accept) begin
        digits_q <= bus.digits;
        bri_q    <= bus.brightness;
        on_q     <= bus.display_on;
      end
    end
  end

`ifdef TM1637_ACK_CHECK_EN
  logic ack_err_q;
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)
      ack_err_q <= 1'b0;
    else if (accept)
      ack_err_q <= 1'b0;
    else if (tick && state_q == ACK_HI && bus.tm_dio_i)
      ack_err_q <= 1'b1;
  end
  assign bus.ack_err = ack_err_q;
`else
  assign bus.ack_err = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tm_clk    = clk_q;
  assign bus.tm_dio_oe = oe_q;
endmodule
